// File: rtl/bp_be_prefetch_scheduler.sv
// Stride prefetch scheduler: learns per-PC strides from committed loads
// and issues start commands to the backend stride prefetch generator.
//
// Ports:
//   clk_i, reset_i (async, active-high)
//   ld_v_i/ld_pc_i/ld_eff_addr_i  committed load observations
//   flush_i                       drop pending command
//   v_o/ready_and_i               command handshake
//   pc_o/eff_addr_o/stride_o/loop_counter_o  command payload
//   issue_count_o/drop_count_o    only with BP_BE_PREFETCH_SCHED_STATS_EN

package bp_be_prefetch_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef enum logic {
    e_empty = 1'b0,
    e_full  = 1'b1
  } pend_state_e;

  function automatic int vaddr_width_f(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

endpackage

module bp_be_prefetch_scheduler
  import bp_be_prefetch_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int entries_p = 8,
  parameter int stride_width_p = 8,
  parameter int loop_range_p = 8,
  parameter int conf_width_p = 2,
  parameter int conf_threshold_p = 2,
  parameter int prefetch_depth_p = 4,
  localparam int vaddr_width_p = vaddr_width_f(bp_params_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      ld_v_i,
  input  logic [vaddr_width_p-1:0]  ld_pc_i,
  input  logic [vaddr_width_p-1:0]  ld_eff_addr_i,
  input  logic                      flush_i,
  output logic                      v_o,
  input  logic                      ready_and_i,
  output logic [vaddr_width_p-1:0]  pc_o,
  output logic [vaddr_width_p-1:0]  eff_addr_o,
  output logic [stride_width_p-1:0] stride_o,
  output logic [loop_range_p-1:0]   loop_counter_o
`ifdef BP_BE_PREFETCH_SCHED_STATS_EN
  ,
  output logic [31:0]               issue_count_o,
  output logic [31:0]               drop_count_o
`endif
);

  localparam int idx_w_lp = $clog2(entries_p);
  localparam int tag_w_lp = vaddr_width_p - 2 - idx_w_lp;
  localparam logic [conf_width_p-1:0] conf_thr_lp =
    conf_width_p'(conf_threshold_p);
  localparam logic [conf_width_p-1:0] conf_max_lp = '1;
  localparam logic [loop_range_p-1:0] depth_lp =
    loop_range_p'(prefetch_depth_p);

  logic [entries_p-1:0]      v_r;
  logic [tag_w_lp-1:0]       tag_r    [entries_p];
  logic [vaddr_width_p-1:0]  addr_r   [entries_p];
  logic [stride_width_p-1:0] stride_r [entries_p];
  logic [conf_width_p-1:0]   conf_r   [entries_p];
  logic [loop_range_p-1:0]   cool_r   [entries_p];

  logic [idx_w_lp-1:0]       idx;
  logic [tag_w_lp-1:0]       tag;
  logic [vaddr_width_p-1:0]  delta;
  logic [conf_width_p-1:0]   conf_inc;
  logic                      hit, legal, match, trig;
  logic                      deq, accept;
  logic                      unused_pc_lsbs;

  pend_state_e state_r, state_n;

  assign unused_pc_lsbs = ^ld_pc_i[1:0];

  assign idx = ld_pc_i[2 +: idx_w_lp];
  assign tag = ld_pc_i[vaddr_width_p-1 -: tag_w_lp];
  assign hit = ld_v_i & v_r[idx] & (tag_r[idx] == tag);

  assign delta = ld_eff_addr_i - addr_r[idx];
  // Legal strides are positive and fit the generator's unsigned field;
  // backwards deltas wrap to huge values and fall out here.
  assign legal = (delta != '0)
               & (delta[vaddr_width_p-1:stride_width_p] == '0);
  assign match = legal & (delta[stride_width_p-1:0] == stride_r[idx]);

  assign conf_inc = (conf_r[idx] == conf_max_lp)
                  ? conf_r[idx]
                  : conf_r[idx] + 1'b1;

  assign trig = hit & match
              & (cool_r[idx] == '0)
              & (conf_inc >= conf_thr_lp);

  assign deq    = v_o & ready_and_i;
  assign accept = trig & ~flush_i & ((state_r == e_empty) | deq);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_empty;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    if (flush_i) begin
      state_n = e_empty;
    end else if (accept) begin
      state_n = e_full;
    end else if (deq) begin
      state_n = e_empty;
    end
  end

  always_comb begin
    v_o = (state_r == e_full);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_o           <= '0;
      eff_addr_o     <= '0;
      stride_o       <= '0;
      loop_counter_o <= '0;
    end else if (accept) begin
      pc_o           <= ld_pc_i;
      eff_addr_o     <= ld_eff_addr_i
                      + vaddr_width_p'(stride_r[idx]);
      stride_o       <= stride_r[idx];
      loop_counter_o <= depth_lp;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_r <= '0;
      for (int i = 0; i < entries_p; i++) begin
        tag_r[i]    <= '0;
        addr_r[i]   <= '0;
        stride_r[i] <= '0;
        conf_r[i]   <= '0;
        cool_r[i]   <= '0;
      end
    end else if (ld_v_i) begin
      if (!hit) begin
        v_r[idx]      <= 1'b1;
        tag_r[idx]    <= tag;
        addr_r[idx]   <= ld_eff_addr_i;
        stride_r[idx] <= '0;
        conf_r[idx]   <= '0;
        cool_r[idx]   <= '0;
      end else begin
        addr_r[idx] <= ld_eff_addr_i;
        if (match) begin
          conf_r[idx] <= conf_inc;
          // A dropped trigger leaves cooldown at zero so the
          // next matching hit retries.
          if (accept) begin
            cool_r[idx] <= depth_lp;
          end else if (cool_r[idx] != '0) begin
            cool_r[idx] <= cool_r[idx] - 1'b1;
          end
        end else begin
          stride_r[idx] <= legal ? delta[stride_width_p-1:0] : '0;
          conf_r[idx]   <= '0;
        end
      end
    end
  end

`ifdef BP_BE_PREFETCH_SCHED_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      issue_count_o <= '0;
      drop_count_o  <= '0;
    end else begin
      if (deq) begin
        issue_count_o <= issue_count_o + 32'd1;
      end
      if (trig & ~accept) begin
        drop_count_o <= drop_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_prefetch_scheduler.sv
// Bench for bp_be_prefetch_scheduler: directed load streams checked
// against a table/queue model every cycle plus literal expectations.
module tb_bp_be_prefetch_scheduler;

  localparam int VA = 39;
  localparam longint unsigned MASK = (64'd1 << VA) - 1;

  logic          clk;
  logic          reset_i;
  logic          ld_v_i;
  logic [VA-1:0] ld_pc_i;
  logic [VA-1:0] ld_eff_addr_i;
  logic          flush_i;
  logic          v_o;
  logic          ready_and_i;
  logic [VA-1:0] pc_o;
  logic [VA-1:0] eff_addr_o;
  logic [7:0]    stride_o;
  logic [7:0]    loop_counter_o;
`ifdef BP_BE_PREFETCH_SCHED_STATS_EN
  logic [31:0]   issue_count_o;
  logic [31:0]   drop_count_o;
`endif

  bp_be_prefetch_scheduler dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .ld_v_i         (ld_v_i),
    .ld_pc_i        (ld_pc_i),
    .ld_eff_addr_i  (ld_eff_addr_i),
    .flush_i        (flush_i),
    .v_o            (v_o),
    .ready_and_i    (ready_and_i),
    .pc_o           (pc_o),
    .eff_addr_o     (eff_addr_o),
    .stride_o       (stride_o),
    .loop_counter_o (loop_counter_o)
`ifdef BP_BE_PREFETCH_SCHED_STATS_EN
    ,
    .issue_count_o  (issue_count_o),
    .drop_count_o   (drop_count_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name,
                              longint unsigned act,
                              longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Model: per-index table and a one-deep pending command.
  bit              m_valid [8];
  longint unsigned m_tag   [8];
  longint unsigned m_last  [8];
  longint unsigned m_strd  [8];
  int              m_conf  [8];
  int              m_cool  [8];
  bit              m_pv;
  longint unsigned m_pc, m_ea, m_st;
  int              m_issue, m_drop;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_conf[i]  = 0;
      m_cool[i]  = 0;
    end
    m_pv = 0;
    m_issue = 0;
    m_drop = 0;
  endtask

  task automatic model_step(bit v, longint unsigned pc,
                            longint unsigned ea, bit fl, bit rdy);
    bit deq, trig, acc, lg;
    int i;
    longint unsigned d, strd;
    deq = m_pv && rdy;
    trig = 0;
    strd = 0;
    i = 0;
    if (v) begin
      i = int'((pc >> 2) % 8);
      if (m_valid[i] && m_tag[i] == (pc >> 5)) begin
        d = (ea - m_last[i]) & MASK;
        lg = (d > 0) && (d < 256);
        m_last[i] = ea;
        if (lg && d == m_strd[i]) begin
          m_conf[i] = (m_conf[i] + 1 > 3) ? 3 : m_conf[i] + 1;
          trig = (m_cool[i] == 0) && (m_conf[i] >= 2);
          if (m_cool[i] > 0) m_cool[i]--;
          strd = d;
        end else begin
          m_strd[i] = lg ? d : 0;
          m_conf[i] = 0;
        end
      end else begin
        m_valid[i] = 1;
        m_tag[i]   = pc >> 5;
        m_last[i]  = ea;
        m_strd[i]  = 0;
        m_conf[i]  = 0;
        m_cool[i]  = 0;
      end
    end
    acc = trig && !fl && (!m_pv || deq);
    if (deq) m_issue++;
    if (trig && !acc) m_drop++;
    if (acc) begin
      m_cool[i] = 4;
      m_pc = pc;
      m_ea = (ea + strd) & MASK;
      m_st = strd;
    end
    if (fl) m_pv = 0;
    else if (acc) m_pv = 1;
    else if (deq) m_pv = 0;
  endtask

  always @(negedge clk) begin
    chk("v_o", v_o, m_pv);
    if (m_pv) begin
      chk("pc_o", pc_o, m_pc);
      chk("eff_addr_o", eff_addr_o, m_ea);
      chk("stride_o", stride_o, m_st);
      chk("loop_counter_o", loop_counter_o, 4);
    end
`ifdef BP_BE_PREFETCH_SCHED_STATS_EN
    chk("issue_count_o", issue_count_o, longint'(m_issue));
    chk("drop_count_o", drop_count_o, longint'(m_drop));
`endif
  end

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cyc(bit v, longint unsigned pc,
                     longint unsigned ea, bit fl, bit rdy);
    ld_v_i = v;
    ld_pc_i = VA'(pc);
    ld_eff_addr_i = VA'(ea);
    flush_i = fl;
    ready_and_i = rdy;
    @(posedge clk);
    #1;
    model_step(v, pc, ea, fl, rdy);
  endtask

  task automatic ld(longint unsigned pc, longint unsigned ea, bit rdy);
    cyc(1, pc, ea, 0, rdy);
  endtask

  task automatic idle(bit rdy);
    cyc(0, 0, 0, 0, rdy);
  endtask

  initial begin
    reset_i = 1;
    ld_v_i = 0;
    ld_pc_i = '0;
    ld_eff_addr_i = '0;
    flush_i = 0;
    ready_and_i = 0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_v", v_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_ea", eff_addr_o, 0);
    chk("rst_stride", stride_o, 0);
    chk("rst_loop", loop_counter_o, 0);
    reset_i = 0;

    // Basic trigger
    ld('h1000, 'h8000, 1);
    ld('h1000, 'h8008, 1);
    ld('h1000, 'h8010, 1);
    chk("basic_no_early", v_o, 0);
    ld('h1000, 'h8018, 1);
    chk("basic_v", v_o, 1);
    chk("basic_pc", pc_o, 'h1000);
    chk("basic_ea", eff_addr_o, 'h8020);
    chk("basic_stride", stride_o, 8);
    chk("basic_loop", loop_counter_o, 4);

    // Cooldown
    for (int k = 0; k < 4; k++) begin
      ld('h1000, 'h8020 + 8 * k, 1);
      chk("cool_quiet", v_o, 0);
    end
    ld('h1000, 'h8040, 1);
    chk("cool_v", v_o, 1);
    chk("cool_ea", eff_addr_o, 'h8048);

    // Backpressure and drop
    ld('h1000, 'h8048, 1);
    for (int k = 0; k < 3; k++) ld('h1000, 'h8050 + 8 * k, 0);
    chk("bp_quiet", v_o, 0);
    ld('h1000, 'h8068, 0);
    chk("bp_v", v_o, 1);
    for (int k = 0; k < 4; k++) begin
      ld('h1004, 'h9000 + 16 * k, 0);
      chk("bp_hold_v", v_o, 1);
      chk("bp_hold_pc", pc_o, 'h1000);
      chk("bp_hold_ea", eff_addr_o, 'h8070);
    end
`ifdef BP_BE_PREFETCH_SCHED_STATS_EN
    chk("bp_drop_cnt", drop_count_o, 1);
`endif
    idle(1);
    chk("bp_deq", v_o, 0);
    ld('h1004, 'h9040, 1);
    chk("bp_retry_v", v_o, 1);
    chk("bp_retry_pc", pc_o, 'h1004);
    chk("bp_retry_ea", eff_addr_o, 'h9050);
    chk("bp_retry_stride", stride_o, 'h10);
    idle(1);

    // Illegal strides
    ld('h1008, 'h8000, 1);
    ld('h1008, 'h7FF8, 1);
    ld('h1008, 'h7FF0, 1);
    ld('h1008, 'h7FE8, 1);
    ld('h1008, 'h7FE0, 1);
    for (int k = 0; k < 5; k++) ld('h100C, 'h200 * k, 1);
    chk("illegal_quiet", v_o, 0);

    // Alias
    ld('h1000, 'h8070, 1);
    ld('h1020, 'hB000, 1);
    ld('h1000, 'hC000, 1);
    ld('h1000, 'hC008, 1);
    ld('h1000, 'hC010, 1);
    chk("alias_quiet", v_o, 0);
    ld('h1000, 'hC018, 1);
    chk("alias_v", v_o, 1);
    chk("alias_ea", eff_addr_o, 'hC020);
    idle(1);

    // Flush
    ld('h1014, 'hD000, 1);
    ld('h1014, 'hD008, 1);
    ld('h1014, 'hD010, 1);
    cyc(1, 'h1014, 'hD018, 1, 1);
    chk("flush_quiet", v_o, 0);
    idle(1);

    // Reset mid-command
    for (int k = 0; k < 4; k++) ld('h1018, 'hE000 + 8 * k, 0);
    chk("rst_mid_pre", v_o, 1);
    ld_v_i = 0;
    #2;
    reset_i = 1;
    model_reset();
    #1;
    chk("rst_mid_v", v_o, 0);
    @(posedge clk);
    #1;
    reset_i = 0;
    for (int k = 0; k < 3; k++) ld('h1018, 'hF000 + 8 * k, 1);
    chk("rst_retrain_quiet", v_o, 0);
    ld('h1018, 'hF018, 1);
    chk("rst_retrain_v", v_o, 1);
    chk("rst_retrain_ea", eff_addr_o, 'hF020);
    idle(1);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
